// File: rtl/moda_pkg.sv
// Shared types and widths for the 16x16 approximate multiplier front end:
// FSM states, partial-product tags and the operand half selector.
package moda_pkg;

    localparam int OP_W   = 16;
    localparam int HALF_W = 8;
    localparam int PP_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [1:0] tag_t;

    localparam tag_t PP_LL = 2'd0;
    localparam tag_t PP_LH = 2'd1;
    localparam tag_t PP_HL = 2'd2;
    localparam tag_t PP_HH = 2'd3;

    // Pick the high or low byte of an operand.
    function automatic logic [HALF_W-1:0] half_sel(input logic [OP_W-1:0] v, input logic hi);
        return hi ? v[OP_W-1:HALF_W] : v[HALF_W-1:0];
    endfunction

endpackage

// File: rtl/mul8_unit.sv
// Exact unsigned 8x8 multiplier with MUL_LAT register stages; the tag and
// valid bit ride alongside the product so the caller knows where it belongs.
module mul8_unit
    import moda_pkg::*;
#(
    parameter int MUL_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [HALF_W-1:0] x,
    input  logic [HALF_W-1:0] y,
    input  logic              in_vld,
    input  tag_t              in_tag,
    output logic [PP_W-1:0]   p,
    output logic              out_vld,
    output tag_t              out_tag
);

    logic [PP_W-1:0] prod_d;
    logic [PP_W-1:0] prod_q [MUL_LAT];
    logic            vld_q  [MUL_LAT];
    tag_t            tag_q  [MUL_LAT];

    always_comb begin
        prod_d = PP_W'(x) * PP_W'(y);
    end

    // Only the control side is reset, so an abort empties the pipe at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                vld_q[i] <= 1'b0;
                tag_q[i] <= PP_LL;
            end
        end else begin
            vld_q[0] <= in_vld;
            tag_q[0] <= in_tag;
            for (int i = 1; i < MUL_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        prod_q[0] <= prod_d;
        for (int i = 1; i < MUL_LAT; i++) begin
            prod_q[i] <= prod_q[i-1];
        end
    end

    assign p       = prod_q[MUL_LAT-1];
    assign out_vld = vld_q[MUL_LAT-1];
    assign out_tag = tag_q[MUL_LAT-1];

endmodule

// File: rtl/pp_gen_seq_16.sv
// Sequential partial-product generator: one shared 8x8 unit produces ll, lh,
// hl, hh over four issue cycles and holds them until the consumer takes them.
module pp_gen_seq_16
    import moda_pkg::*;
#(
    parameter int MUL_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PP_W-1:0] ll,
    output logic [PP_W-1:0] lh,
    output logic [PP_W-1:0] hl,
    output logic [PP_W-1:0] hh
);

    state_t          state_q, state_d;
    tag_t            idx_q, idx_d;
    logic [OP_W-1:0] a_q, a_d, b_q, b_d;
    logic            out_valid_q, out_valid_d;
    logic [PP_W-1:0] slot_q [4];
    logic [PP_W-1:0] slot_d [4];

    logic [HALF_W-1:0] mul_x, mul_y;
    logic              mul_in_vld;
    logic [PP_W-1:0]   mul_p;
    logic              mul_out_vld;
    tag_t              mul_out_tag;
    logic              accept;

    // A finished result may be replaced in the same cycle it is handed off.
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // idx[1] selects the high byte of a, idx[0] the high byte of b.
    assign mul_x      = half_sel(a_q, idx_q[1]);
    assign mul_y      = half_sel(b_q, idx_q[0]);
    assign mul_in_vld = (state_q == ISSUE);

    mul8_unit #(.MUL_LAT(MUL_LAT)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .x       (mul_x),
        .y       (mul_y),
        .in_vld  (mul_in_vld),
        .in_tag  (idx_q),
        .p       (mul_p),
        .out_vld (mul_out_vld),
        .out_tag (mul_out_tag)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        out_valid_d = out_valid_q;
        slot_d      = slot_q;

        if (mul_out_vld) begin
            slot_d[mul_out_tag] = mul_p;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = PP_LL;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == PP_HH) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mul_out_vld && (mul_out_tag == PP_HH)) begin
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (accept) begin
                        a_d     = a;
                        b_d     = b;
                        idx_d   = PP_LL;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= PP_LL;
            a_q         <= '0;
            b_q         <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign ll        = slot_q[PP_LL];
    assign lh        = slot_q[PP_LH];
    assign hl        = slot_q[PP_HL];
    assign hh        = slot_q[PP_HH];

endmodule

// File: tb/tb_pp_gen_seq_16.sv
// Bench for pp_gen_seq_16: directed steps on a MUL_LAT=1 instance, then a
// randomized stall run on a MUL_LAT=2 instance against a byte-product model.
module tb_pp_gen_seq_16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        iv1, ir1, ov1, or1;
    logic [15:0] a1, b1, ll1, lh1, hl1, hh1;
    logic        iv2, ir2, ov2, or2;
    logic [15:0] a2, b2, ll2, lh2, hl2, hh2;

    pp_gen_seq_16 #(.MUL_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .out_valid(ov1), .out_ready(or1), .ll(ll1), .lh(lh1), .hl(hl1), .hh(hh1)
    );

    pp_gen_seq_16 #(.MUL_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
        .out_valid(ov2), .out_ready(or2), .ll(ll2), .lh(lh2), .hl(hl2), .hh(hh2)
    );

    typedef struct packed {
        logic [15:0] ll;
        logic [15:0] lh;
        logic [15:0] hl;
        logic [15:0] hh;
    } pp_t;

    pp_t q1[$];
    pp_t q2[$];
    int  checks   = 0;
    int  failures = 0;

    function automatic pp_t model(input logic [15:0] a, input logic [15:0] b);
        pp_t r;
        r.ll = 16'(a[7:0])  * 16'(b[7:0]);
        r.lh = 16'(a[7:0])  * 16'(b[15:8]);
        r.hl = 16'(a[15:8]) * 16'(b[7:0]);
        r.hh = 16'(a[15:8]) * 16'(b[15:8]);
        return r;
    endfunction

    function automatic pp_t all4(input logic [15:0] v);
        pp_t r;
        r.ll = v; r.lh = v; r.hl = v; r.hh = v;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp4(input string tag, input pp_t obs, input pp_t exp);
        chk({tag, "_ll"}, 32'(obs.ll), 32'(exp.ll));
        chk({tag, "_lh"}, 32'(obs.lh), 32'(exp.lh));
        chk({tag, "_hl"}, 32'(obs.hl), 32'(exp.hl));
        chk({tag, "_hh"}, 32'(obs.hh), 32'(exp.hh));
    endtask

    function automatic pp_t obs1();
        pp_t r;
        r.ll = ll1; r.lh = lh1; r.hl = hl1; r.hh = hh1;
        return r;
    endfunction

    function automatic pp_t obs2();
        pp_t r;
        r.ll = ll2; r.lh = lh2; r.hl = hl2; r.hh = hh2;
        return r;
    endfunction

    // Offers a,b from IDLE; returns at the falling edge of the first cycle after acceptance.
    task automatic accept1(input logic [15:0] a, input logic [15:0] b, input pp_t exp);
        @(negedge clk);
        iv1 = 1'b1; a1 = a; b1 = b;
        #1 chk("in_ready_idle", 32'(ir1), 32'd1);
        q1.push_back(exp);
        @(negedge clk);
        iv1 = 1'b0;
    endtask

    task automatic wait_valid1(input string tag, input int lat);
        int cyc = 1;
        while (!ov1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk(tag, 32'(cyc), 32'(lat));
    endtask

    task automatic cmp_front1(input string tag);
        pp_t e;
        chk({tag, "_sb"}, 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) begin
            e = q1.pop_front();
            cmp4(tag, obs1(), e);
        end
    endtask

    task automatic consume1();
        or1 = 1'b1;
        @(negedge clk);
        or1 = 1'b0;
        #1 chk("out_valid_drop", 32'(ov1), 32'd0);
    endtask

    initial begin
        pp_t held;
        pp_t e;
        int  spurious;
        int  cyc;
        int  ops_done;
        logic pend;

        rst_n = 1'b0;
        iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0;
        iv2 = 1'b0; or2 = 1'b0; a2 = '0; b2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(ir1), 32'd1);
        chk("rst_out_valid", 32'(ov1), 32'd0);
        cmp4("rst_slots", obs1(), all4(16'h0000));
        chk("rst_in_ready2", 32'(ir2), 32'd1);
        chk("rst_out_valid2", 32'(ov2), 32'd0);
        rst_n = 1'b1;

        accept1(16'h1234, 16'h5678, '{16'h1860, 16'h1178, 16'h0870, 16'h060C});
        wait_valid1("lat_1234", 6);
        cmp_front1("pp_1234");
        consume1();

        accept1(16'hFFFF, 16'hFFFF, all4(16'hFE01));
        wait_valid1("lat_ffff", 6);
        held = obs1();
        cmp_front1("pp_ffff");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            iv1 = i[0]; a1 = 16'($urandom); b1 = 16'($urandom);
            #1;
            chk("hold_in_ready", 32'(ir1), 32'd0);
            chk("hold_out_valid", 32'(ov1), 32'd1);
            cmp4("hold", obs1(), held);
        end
        iv1 = 1'b0;
        consume1();
        chk("no_capture_idle", 32'(ir1), 32'd1);

        accept1(16'h0000, 16'hFFFF, all4(16'h0000));
        wait_valid1("lat_zero", 6);
        cmp_front1("pp_zero");

        or1 = 1'b1; iv1 = 1'b1; a1 = 16'h0100; b1 = 16'h0001;
        #1 chk("b2b_in_ready", 32'(ir1), 32'd1);
        q1.push_back('{16'h0000, 16'h0000, 16'h0001, 16'h0000});
        @(negedge clk);
        or1 = 1'b0; iv1 = 1'b0;
        #1 chk("b2b_out_valid_low", 32'(ov1), 32'd0);
        wait_valid1("lat_b2b", 6);
        cmp_front1("pp_b2b");
        consume1();

        accept1(16'h1234, 16'h5678, model(16'h1234, 16'h5678));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(ov1), 32'd0);
        chk("abort_in_ready", 32'(ir1), 32'd1);
        cmp4("abort_slots", obs1(), all4(16'h0000));
        @(negedge clk);
        rst_n = 1'b1;
        q1.delete();
        spurious = 0;
        repeat (15) begin
            @(negedge clk);
            if (ov1) spurious++;
        end
        chk("abort_no_spurious", 32'(spurious), 32'd0);
        chk("abort_idle", 32'(ir1), 32'd1);

        @(negedge clk);
        a2 = 16'($urandom); b2 = 16'($urandom); iv2 = 1'b1;
        #1 chk("ml2_in_ready", 32'(ir2), 32'd1);
        q2.push_back(model(a2, b2));
        @(negedge clk);
        iv2 = 1'b0;
        cyc = 1;
        while (!ov2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("ml2_latency", 32'(cyc), 32'd7);
        e = q2.pop_front();
        cmp4("ml2_first", obs2(), e);
        or2 = 1'b1;
        @(negedge clk);
        or2 = 1'b0;

        ops_done = 0;
        cyc = 0;
        pend = 1'b0;
        while (ops_done < 1000 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (!pend && $urandom_range(0, 9) < 7) begin
                pend = 1'b1;
                a2 = 16'($urandom);
                b2 = 16'($urandom);
            end
            iv2 = pend;
            or2 = ($urandom_range(0, 9) < 6);
            #1;
            if (ov2 && or2) begin
                chk("rnd_sb", 32'(q2.size() != 0), 32'd1);
                if (q2.size() != 0) begin
                    e = q2.pop_front();
                    cmp4("rnd", obs2(), e);
                end
                ops_done++;
            end
            if (iv2 && ir2) begin
                q2.push_back(model(a2, b2));
                pend = 1'b0;
            end
        end
        iv2 = 1'b0;
        or2 = 1'b0;
        chk("rnd_ops_done", 32'(ops_done), 32'd1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
